parc_core_reorder_buffer: RTL and testbench
===========================================

PARC_CORE_REORDER_BUFFER -- requirements
Module: parc_core_reorder_buffer

Interface
REQ-001 SHALL have the port: clk  input  1  core clock; all state updates on its rising edge.
REQ-002 SHALL have the port: reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have the port: rob_alloc_req_val  input  1  decode requests a slot for an accepted instruction writing a destination register.
REQ-004 SHALL have the port: rob_alloc_req_rdy  output  1  buffer can accept an allocation this cycle.
REQ-005 SHALL have the port: rob_alloc_req_preg  input  5  destination register of the allocating instruction.
REQ-006 SHALL have the port: rob_alloc_resp_slot  output  4  slot granted to the allocating instruction, valid in the same cycle as the request.
REQ-007 SHALL have the port: rob_fill_val  input  1  writeback reports a completed result.
REQ-008 SHALL have the port: rob_fill_slot  input  4  slot of the completed result.
REQ-009 SHALL have the port: rob_commit_wen  output  1  head slot retires this cycle.
REQ-010 SHALL have the port: rob_commit_slot  output  4  slot retiring this cycle.
REQ-011 SHALL have the port: rob_commit_rf_waddr  output  5  register-file write address of the retiring slot.
REQ-012 SHALL have the port: rob_commit_rf_wen  output  1  register file is written at commit.

Function
REQ-013 SHALL hold 16 entries; each entry has valid, pending and preg[4:0]; a 4-bit head pointer, a 4-bit tail pointer and a 5-bit count (0..16) SHALL be kept.
REQ-014 SHALL drive rob_alloc_req_rdy = (count < 16), combinationally; a commit in the same cycle SHALL NOT raise rdy when full.
REQ-015 SHALL drive rob_alloc_resp_slot = tail combinationally at all times.
REQ-016 SHALL, on val && rdy, set entry[tail] valid=1, pending=1, preg=rob_alloc_req_preg, and advance tail by 1 mod 16 (15 wraps to 0).
REQ-017 SHALL, on rob_fill_val with entry[rob_fill_slot] valid, clear that entry's pending bit at the next edge; a fill to an invalid slot SHALL be ignored.
REQ-018 SHALL drive rob_commit_wen = valid[head] && !pending[head], rob_commit_slot = head and rob_commit_rf_waddr = preg[head], all combinationally; rob_commit_wen SHALL be 0 when count == 0.
REQ-019 SHALL, when rob_commit_wen is 1, clear entry[head] valid and pending and advance head by 1 mod 16 at the next edge; commit SHALL be strictly in allocation order, at most one entry per cycle.
REQ-020 SHALL make a filled head retire exactly one cycle after the fill cycle; a fill never bypasses to commit in the same cycle.
REQ-021 SHALL update count as count + alloc_fire - commit; a simultaneous alloc and commit SHALL leave count unchanged.
REQ-022 SHALL, in builds without the squash feature, drive rob_commit_rf_wen = rob_commit_wen.
REQ-023 SHALL give simultaneous alloc, fill and commit to distinct slots independent effect in the same edge.

Reset
REQ-024 SHALL, on reset, clear head, tail, count and all valid, pending and preg bits to 0; reset SHALL take priority over any same-cycle alloc, fill or commit.
REQ-025 SHALL hold these output values during and after reset: rdy=1, resp_slot=0, commit_wen=0, commit_slot=0, rf_waddr=0, rf_wen=0.

Configuration
REQ-026 SHALL, when macro PARC_ROB_SQUASH_EN is defined:
- add inputs rob_squash_val (1 bit) and rob_squash_slot (4 bits);
- keep a per-entry squashed bit, which reset and allocation clear to 0;
- a squash to a valid slot sets squashed=1 and pending=0;
- a squashed entry retires normally with rob_commit_wen=1 and rob_commit_rf_wen=0;
- squash and fill to the same slot in the same cycle result in squashed=1.
REQ-027 SHALL, when PARC_ROB_SQUASH_EN is undefined, have no squash ports and no squashed state.

Verification
REQ-028 Reset, then alloc preg=5 -> resp_slot=0; next cycle rdy=1 and commit_wen=0; fill slot 0 -> commit_wen=1, slot=0, rf_waddr=5 the cycle after the fill.
REQ-029 Alloc slots 0,1,2, fill order 2,1,0 -> commits occur for slots 0,1,2 on consecutive cycles, none before slot 0 is filled.
REQ-030 Allocate 16 back-to-back -> rdy=0 after the 16th; fill slot 0 and hold alloc request -> slot 0 commits, rdy=1 the next cycle, new alloc granted slot 0 (wrap).
REQ-031 Full buffer with commit and alloc_val in the same cycle -> alloc not accepted, count=15 afterwards; fill to an unallocated slot 9 -> no state change.
REQ-032 With PARC_ROB_SQUASH_EN: alloc slots 0 and 1, squash slot 1, fill slot 0 -> slot 0 commits with rf_wen=1, then slot 1 commits with commit_wen=1 and rf_wen=0.
REQ-033 Assert reset while 3 entries are pending -> next cycle count=0, commit_wen=0, and the next alloc is granted slot 0.

Source files
------------

// File: rtl/parc_core_reorder_buffer_if.sv
// parc_core_reorder_buffer_if: allocate/fill/commit bus between the pipeline and the reorder buffer.
// Squash signals exist only when PARC_ROB_SQUASH_EN is defined.
interface parc_core_reorder_buffer_if;
   logic       rob_alloc_req_val;
   logic       rob_alloc_req_rdy;
   logic [4:0] rob_alloc_req_preg;
   logic [3:0] rob_alloc_resp_slot;
   logic       rob_fill_val;
   logic [3:0] rob_fill_slot;
   logic       rob_commit_wen;
   logic [3:0] rob_commit_slot;
   logic [4:0] rob_commit_rf_waddr;
   logic       rob_commit_rf_wen;
`ifdef PARC_ROB_SQUASH_EN
   logic       rob_squash_val;
   logic [3:0] rob_squash_slot;
   modport master (
      output rob_alloc_req_val, rob_alloc_req_preg, rob_fill_val, rob_fill_slot,
             rob_squash_val, rob_squash_slot,
      input  rob_alloc_req_rdy, rob_alloc_resp_slot, rob_commit_wen, rob_commit_slot,
             rob_commit_rf_waddr, rob_commit_rf_wen
   );
   modport slave (
      input  rob_alloc_req_val, rob_alloc_req_preg, rob_fill_val, rob_fill_slot,
             rob_squash_val, rob_squash_slot,
      output rob_alloc_req_rdy, rob_alloc_resp_slot, rob_commit_wen, rob_commit_slot,
             rob_commit_rf_waddr, rob_commit_rf_wen
   );
`else
   modport master (
      output rob_alloc_req_val, rob_alloc_req_preg, rob_fill_val, rob_fill_slot,
      input  rob_alloc_req_rdy, rob_alloc_resp_slot, rob_commit_wen, rob_commit_slot,
             rob_commit_rf_waddr, rob_commit_rf_wen
   );
   modport slave (
      input  rob_alloc_req_val, rob_alloc_req_preg, rob_fill_val, rob_fill_slot,
      output rob_alloc_req_rdy, rob_alloc_resp_slot, rob_commit_wen, rob_commit_slot,
             rob_commit_rf_waddr, rob_commit_rf_wen
   );
`endif
endinterface

// File: rtl/parc_core_reorder_buffer.sv
// parc_core_reorder_buffer: 16-entry in-order-commit reorder buffer.
// Define PARC_ROB_SQUASH_EN to add squash support (squashed entries retire without a register write).
module parc_core_reorder_buffer (
   input logic clk,
   input logic reset,
   parc_core_reorder_buffer_if.slave rob
);
   logic [15:0] valid, pending;
   logic [4:0]  preg [16];
   logic [3:0]  head, tail;
   logic [4:0]  count;
   logic        alloc, commit;
`ifdef PARC_ROB_SQUASH_EN
   logic [15:0] squashed;
`endif
   assign rob.rob_alloc_req_rdy   = count < 5'd16;
   assign rob.rob_alloc_resp_slot = tail;
   assign alloc                   = rob.rob_alloc_req_val && rob.rob_alloc_req_rdy;
   assign commit                  = valid[head] && !pending[head];
   assign rob.rob_commit_wen      = commit;
   assign rob.rob_commit_slot     = head;
   assign rob.rob_commit_rf_waddr = preg[head];
`ifdef PARC_ROB_SQUASH_EN
   assign rob.rob_commit_rf_wen   = commit && !squashed[head];
`else
   assign rob.rob_commit_rf_wen   = commit;
`endif
   // Fill/squash first, then commit, then alloc: later writes win if slots ever coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         valid   <= '0;
         pending <= '0;
         preg    <= '{default: '0};
`ifdef PARC_ROB_SQUASH_EN
         squashed <= '0;
`endif
      end else begin
         if (rob.rob_fill_val && valid[rob.rob_fill_slot])
            pending[rob.rob_fill_slot] <= 1'b0;
`ifdef PARC_ROB_SQUASH_EN
         if (rob.rob_squash_val && valid[rob.rob_squash_slot]) begin
            pending[rob.rob_squash_slot]  <= 1'b0;
            squashed[rob.rob_squash_slot] <= 1'b1;
         end
`endif
         if (commit) begin
            valid[head]   <= 1'b0;
            pending[head] <= 1'b0;
            head          <= head + 4'd1;
         end
         if (alloc) begin
            valid[tail]   <= 1'b1;
            pending[tail] <= 1'b1;
            preg[tail]    <= rob.rob_alloc_req_preg;
            tail          <= tail + 4'd1;
`ifdef PARC_ROB_SQUASH_EN
            squashed[tail] <= 1'b0;
`endif
         end
         count <= count + 5'(alloc) - 5'(commit);
      end
   end
endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// tb_parc_core_reorder_buffer: directed self-checking bench for the reorder buffer.
module tb_parc_core_reorder_buffer;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fails  = 0;

   parc_core_reorder_buffer_if bus ();
   parc_core_reorder_buffer dut (.clk(clk), .reset(reset), .rob(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic check_commit(input string tag, input logic wen, input logic [3:0] slot,
                               input logic [4:0] waddr, input logic rf_wen);
      check({tag, "_wen"}, 8'(bus.rob_commit_wen), 8'(wen));
      check({tag, "_slot"}, 8'(bus.rob_commit_slot), 8'(slot));
      check({tag, "_waddr"}, 8'(bus.rob_commit_rf_waddr), 8'(waddr));
      check({tag, "_rfwen"}, 8'(bus.rob_commit_rf_wen), 8'(rf_wen));
   endtask

   initial begin
      reset = 1'b1;
      bus.rob_alloc_req_val  = 1'b0;
      bus.rob_alloc_req_preg = '0;
      bus.rob_fill_val       = 1'b0;
      bus.rob_fill_slot      = '0;
`ifdef PARC_ROB_SQUASH_EN
      bus.rob_squash_val     = 1'b0;
      bus.rob_squash_slot    = '0;
`endif
      tick();
      tick();
      check("rst_rdy", 8'(bus.rob_alloc_req_rdy), 8'd1);
      check("rst_resp", 8'(bus.rob_alloc_resp_slot), 8'd0);
      check_commit("rst", 1'b0, 4'd0, 5'd0, 1'b0);
      reset = 1'b0;
      settle();
      check("post_rst_rdy", 8'(bus.rob_alloc_req_rdy), 8'd1);

      // Single allocate, fill, commit
      bus.rob_alloc_req_val = 1'b1; bus.rob_alloc_req_preg = 5'd5;
      settle();
      check("a1_resp", 8'(bus.rob_alloc_resp_slot), 8'd0);
      tick();
      bus.rob_alloc_req_val = 1'b0;
      settle();
      check("a1_rdy", 8'(bus.rob_alloc_req_rdy), 8'd1);
      check("a1_wen_pending", 8'(bus.rob_commit_wen), 8'd0);
      check("a1_tail", 8'(bus.rob_alloc_resp_slot), 8'd1);
      bus.rob_fill_val = 1'b1; bus.rob_fill_slot = 4'd0;
      settle();
      check("a1_no_bypass", 8'(bus.rob_commit_wen), 8'd0);
      tick();
      bus.rob_fill_val = 1'b0;
      settle();
      check_commit("a1_commit", 1'b1, 4'd0, 5'd5, 1'b1);
      tick();
      check("a1_after_wen", 8'(bus.rob_commit_wen), 8'd0);
      check("a1_after_head", 8'(bus.rob_commit_slot), 8'd1);

      // Out-of-order fill, in-order commit
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.rob_alloc_req_val = 1'b1; bus.rob_alloc_req_preg = 5'(10 + i);
         settle();
         check("ooo_resp", 8'(bus.rob_alloc_resp_slot), 8'(i));
         tick();
      end
      bus.rob_alloc_req_val = 1'b0;
      bus.rob_fill_val = 1'b1; bus.rob_fill_slot = 4'd2;
      tick();
      check("ooo_f2_wen", 8'(bus.rob_commit_wen), 8'd0);
      bus.rob_fill_slot = 4'd1;
      tick();
      check("ooo_f1_wen", 8'(bus.rob_commit_wen), 8'd0);
      bus.rob_fill_slot = 4'd0;
      tick();
      bus.rob_fill_val = 1'b0;
      settle();
      check_commit("ooo_c0", 1'b1, 4'd0, 5'd10, 1'b1);
      tick();
      check_commit("ooo_c1", 1'b1, 4'd1, 5'd11, 1'b1);
      tick();
      check_commit("ooo_c2", 1'b1, 4'd2, 5'd12, 1'b1);
      tick();
      check("ooo_empty_wen", 8'(bus.rob_commit_wen), 8'd0);

      // Fill up, then commit and alloc in the same cycle while full, then wrap
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.rob_alloc_req_val = 1'b1; bus.rob_alloc_req_preg = 5'(i);
         settle();
         check("full_resp", 8'(bus.rob_alloc_resp_slot), 8'(i));
         tick();
      end
      check("full_rdy", 8'(bus.rob_alloc_req_rdy), 8'd0);
      check("full_tail_wrap", 8'(bus.rob_alloc_resp_slot), 8'd0);
      bus.rob_alloc_req_preg = 5'd20;
      bus.rob_fill_val = 1'b1; bus.rob_fill_slot = 4'd0;
      tick();
      bus.rob_fill_val = 1'b0;
      settle();
      check_commit("full_c0", 1'b1, 4'd0, 5'd0, 1'b1);
      check("full_commit_rdy", 8'(bus.rob_alloc_req_rdy), 8'd0);
      tick();
      check("full_after_rdy", 8'(bus.rob_alloc_req_rdy), 8'd1);
      check("full_after_resp", 8'(bus.rob_alloc_resp_slot), 8'd0);
      check("full_after_wen", 8'(bus.rob_commit_wen), 8'd0);
      check("full_after_head", 8'(bus.rob_commit_slot), 8'd1);
      tick();
      bus.rob_alloc_req_val = 1'b0;
      settle();
      check("wrap_rdy", 8'(bus.rob_alloc_req_rdy), 8'd0);
      check("wrap_resp", 8'(bus.rob_alloc_resp_slot), 8'd1);

      // Fill to unallocated slot is ignored
      do_reset();
      bus.rob_alloc_req_val = 1'b1; bus.rob_alloc_req_preg = 5'd3;
      tick();
      bus.rob_alloc_req_val = 1'b0;
      bus.rob_fill_val = 1'b1; bus.rob_fill_slot = 4'd9;
      tick();
      bus.rob_fill_val = 1'b0;
      settle();
      check("f9_wen", 8'(bus.rob_commit_wen), 8'd0);
      check("f9_head", 8'(bus.rob_commit_slot), 8'd0);
      check("f9_resp", 8'(bus.rob_alloc_resp_slot), 8'd1);
      check("f9_rdy", 8'(bus.rob_alloc_req_rdy), 8'd1);

      // Reset with pending entries, plus same-cycle alloc/fill that reset must override
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.rob_alloc_req_val = 1'b1; bus.rob_alloc_req_preg = 5'(i + 1);
         tick();
      end
      reset = 1'b1;
      bus.rob_fill_val = 1'b1; bus.rob_fill_slot = 4'd0;
      tick();
      reset = 1'b0;
      bus.rob_alloc_req_val = 1'b0; bus.rob_fill_val = 1'b0;
      settle();
      check_commit("rp_after", 1'b0, 4'd0, 5'd0, 1'b0);
      check("rp_rdy", 8'(bus.rob_alloc_req_rdy), 8'd1);
      check("rp_resp", 8'(bus.rob_alloc_resp_slot), 8'd0);
      bus.rob_alloc_req_val = 1'b1; bus.rob_alloc_req_preg = 5'd7;
      tick();
      bus.rob_alloc_req_val = 1'b0;
      check("rp_alloc_resp", 8'(bus.rob_alloc_resp_slot), 8'd1);
      bus.rob_fill_val = 1'b1; bus.rob_fill_slot = 4'd0;
      tick();
      bus.rob_fill_val = 1'b0;
      settle();
      check_commit("rp_commit", 1'b1, 4'd0, 5'd7, 1'b1);

`ifdef PARC_ROB_SQUASH_EN
      do_reset();
      for (int i = 0; i < 2; i++) begin
         bus.rob_alloc_req_val = 1'b1; bus.rob_alloc_req_preg = 5'(i + 4);
         tick();
      end
      bus.rob_alloc_req_val = 1'b0;
      bus.rob_squash_val = 1'b1; bus.rob_squash_slot = 4'd1;
      bus.rob_fill_val = 1'b1; bus.rob_fill_slot = 4'd1;
      tick();
      bus.rob_squash_val = 1'b0;
      bus.rob_fill_slot = 4'd0;
      tick();
      bus.rob_fill_val = 1'b0;
      settle();
      check_commit("sq_c0", 1'b1, 4'd0, 5'd4, 1'b1);
      tick();
      check_commit("sq_c1", 1'b1, 4'd1, 5'd5, 1'b0);
      tick();
      check("sq_empty", 8'(bus.rob_commit_wen), 8'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
